// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, digit width and digit increment helper
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
  localparam int DIGIT_W = 4;
  localparam int MAX_DIGITS = 8;
  function automatic logic [DIGIT_W-1:0] wrap_inc(input logic [DIGIT_W-1:0] v, input int modulo);
    return v == DIGIT_W'(modulo - 1) ? '0 : v + 1'b1;
  endfunction
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and display outputs of the stopwatch
interface stopwatch_ctrl_if #(parameter int DIGITS = 4);
  logic              btn_ss;
  logic              btn_clr;
  logic              btn_lap;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              running;
  logic              overflow;
  modport master (output btn_ss, btn_clr, btn_lap, input seg, an, running, overflow);
  modport slave (input btn_ss, btn_clr, btn_lap, output seg, an, running, overflow);
endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// btn_edge: registers a debounced level and emits a one-cycle pulse on its rising edge
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic evt_o
);
  logic lvl_q, dly_q;
  // sample the level, keep the previous sample for edge detection
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lvl_q <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      lvl_q <= btn_i;
      dly_q <= lvl_q;
    end
  assign evt_o = lvl_q & ~dly_q;
endmodule

// File: rtl/stopwatch_ctrl_hex7seg.sv
// hex7seg: hex nibble to active-high gfedcba segment pattern
module hex7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  // fixed lookup of the sixteen glyphs
  always_comb
    case (hex_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      default: seg_o = 7'h71;
    endcase
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/clear FSM, prescaled cascaded digit counter, scanned 7-seg display; LAP_HOLD_EN adds a lap-hold snapshot
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int MODULO   = 5,
  parameter int TICK_DIV = 50000,
  parameter int SCAN_DIV = 1000
) (
  input logic clk,
  input logic rst,
  stopwatch_ctrl_if.slave bus
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t             state_q;
  logic [PW-1:0]      pre_q, pre_d;
  logic [DIGIT_W-1:0] dig_q [DIGITS];
  logic [DIGIT_W-1:0] dig_d [DIGITS];
  logic [DIGIT_W-1:0] disp;
  logic [SW-1:0]      scnt_q;
  logic [IW-1:0]      idx_q;
  logic               ovf_q, ovf_d, cy;
  logic               ss_e, clr_e, tick, clear, scan_wrap;
  btn_edge u_ss (.clk(clk), .rst(rst), .btn_i(bus.btn_ss), .evt_o(ss_e));
  btn_edge u_clr (.clk(clk), .rst(rst), .btn_i(bus.btn_clr), .evt_o(clr_e));
  assign tick  = state_q == RUN && pre_q == PW'(TICK_DIV - 1);
  assign clear = state_q != RUN && clr_e;
  assign pre_d = clear || tick ? '0 : state_q == RUN ? pre_q + 1'b1 : pre_q;
  // ripple the tick upward: a digit advances only while every lower digit sits at its max
  always_comb begin
    cy = tick;
    for (int k = 0; k < DIGITS; k++) begin
      dig_d[k] = clear ? '0 : cy ? wrap_inc(dig_q[k], MODULO) : dig_q[k];
      cy = cy && dig_q[k] == DIGIT_W'(MODULO - 1);
    end
    ovf_d = cy;
  end
  // FSM with prescaler, digit chain and overflow pulse; clr beats ss outside RUN, ss alone matters in RUN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      dig_q   <= '{default: '0};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= clear ? IDLE : ss_e ? (state_q == RUN ? PAUSE : RUN) : state_q;
      pre_q   <= pre_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
    end
  assign scan_wrap = scnt_q == SW'(SCAN_DIV - 1);
  // free-running scan: dwell SCAN_DIV cycles on each digit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      scnt_q <= '0;
      idx_q  <= '0;
    end else begin
      scnt_q <= scan_wrap ? '0 : scnt_q + 1'b1;
      if (scan_wrap) idx_q <= idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    end
`ifdef LAP_HOLD_EN
  logic               lap_e, hold_q;
  logic [DIGIT_W-1:0] snap_q [DIGITS];
  btn_edge u_lap (.clk(clk), .rst(rst), .btn_i(bus.btn_lap), .evt_o(lap_e));
  // lap toggles hold while running; entering hold freezes the displayed digits
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold_q <= 1'b0;
      snap_q <= '{default: '0};
    end else if (clear) hold_q <= 1'b0;
    else if (lap_e && state_q == RUN) begin
      hold_q <= !hold_q;
      if (!hold_q) snap_q <= dig_q;
    end
  assign disp = hold_q ? snap_q[idx_q] : dig_q[idx_q];
`else
  logic unused_lap;
  assign unused_lap = bus.btn_lap;
  assign disp = dig_q[idx_q];
`endif
  hex7seg u_dec (.hex_i(disp), .seg_o(bus.seg));
  assign bus.an       = DIGITS'(1) << idx_q;
  assign bus.running  = state_q == RUN;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random button stimulus checked every cycle against an arithmetic stopwatch model
module tb_stopwatch_ctrl;
  localparam int DIGITS = 2, MODULO = 5, TICK_DIV = 2, SCAN_DIV = 3;
  localparam int FULL = MODULO ** DIGITS;
  logic clk = 1'b0;
  logic rst = 1'b1;
  stopwatch_ctrl_if #(.DIGITS(DIGITS)) bus ();
  stopwatch_ctrl #(.DIGITS(DIGITS), .MODULO(MODULO), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  // model: state 0 idle / 1 run / 2 pause, count as a single integer of elapsed ticks mod FULL
  int m_st, m_cnt, m_pre, m_ovf, m_cyc, m_hold, m_snap;
  bit r_ss, p_ss, r_clr, p_clr, r_lap, p_lap;
  function automatic logic [6:0] dec7(input int v);
    case (v)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction
  function automatic int digit(input int val, input int k);
    return (val / (MODULO ** k)) % MODULO;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_pre = 0; m_ovf = 0; m_cyc = 0; m_hold = 0; m_snap = 0;
    r_ss = 0; p_ss = 0; r_clr = 0; p_clr = 0; r_lap = 0; p_lap = 0;
  endtask
  task automatic model_edge();
    bit ess, eclr, elap;
    int ost, ocnt;
    ess = r_ss && !p_ss; eclr = r_clr && !p_clr; elap = r_lap && !p_lap;
    ost = m_st; ocnt = m_cnt;
    m_ovf = 0;
    if (ost == 1) begin
      if (m_pre == TICK_DIV - 1) begin
        m_pre = 0;
        m_cnt = m_cnt + 1;
        if (m_cnt == FULL) begin m_cnt = 0; m_ovf = 1; end
      end else m_pre = m_pre + 1;
    end
`ifdef LAP_HOLD_EN
    if (ost == 1 && elap) begin
      if (m_hold == 0) m_snap = ocnt;
      m_hold = 1 - m_hold;
    end
`else
    if (elap) m_hold = 0;
`endif
    if (ost != 1 && eclr) begin m_st = 0; m_cnt = 0; m_pre = 0; m_hold = 0; end
    else if (ess) m_st = ost == 1 ? 2 : 1;
    m_cyc++;
    p_ss = r_ss; r_ss = bus.btn_ss;
    p_clr = r_clr; r_clr = bus.btn_clr;
    p_lap = r_lap; r_lap = bus.btn_lap;
  endtask
  task automatic check_outputs();
    int idx, shown;
    idx = (m_cyc / SCAN_DIV) % DIGITS;
    shown = m_hold != 0 ? m_snap : m_cnt;
    check("an", 32'(bus.an), 32'(1 << idx));
    check("seg", 32'(bus.seg), 32'(dec7(digit(shown, idx))));
    check("running", 32'(bus.running), 32'(m_st == 1));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end
  endtask
  task automatic press(input bit s, input bit c, input bit l, input int hold);
    bus.btn_ss = s; bus.btn_clr = c; bus.btn_lap = l;
    cycles(hold);
    bus.btn_ss = 0; bus.btn_clr = 0; bus.btn_lap = 0;
    cycles(2);
  endtask
  task automatic async_reset();
    #2 rst = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk) rst = 1;
  endtask
  initial begin
    bus.btn_ss = 0; bus.btn_clr = 0; bus.btn_lap = 0;
    #1 rst = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk) rst = 1;
    cycles(4);
    press(1, 0, 0, 3);
    cycles(20);
    cycles(40);
    press(1, 0, 0, 2);
    cycles(50);
    press(1, 0, 0, 1);
    press(0, 1, 0, 2);
    cycles(5);
    press(1, 0, 0, 1);
    press(1, 1, 0, 2);
    cycles(6);
    press(1, 0, 0, 1);
    cycles(1);
    press(1, 0, 0, 1);
    press(1, 0, 0, 1);
    cycles(9);
    async_reset();
    cycles(7);
    press(1, 0, 0, 4);
    for (int i = 0; i < 200 && m_cnt != 3; i++) cycles(1);
    press(0, 0, 1, 1);
    cycles(12);
    press(0, 0, 1, 1);
    cycles(8);
    press(1, 0, 1, 1);
    press(0, 1, 0, 1);
    repeat (700) begin
      if ($urandom_range(0, 6) == 0) bus.btn_ss = ~bus.btn_ss;
      if ($urandom_range(0, 30) == 0) bus.btn_clr = ~bus.btn_clr;
      if ($urandom_range(0, 8) == 0) bus.btn_lap = ~bus.btn_lap;
      cycles(1);
      if ($urandom_range(0, 250) == 0) async_reset();
    end
    bus.btn_ss = 0; bus.btn_clr = 0; bus.btn_lap = 0;
    cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
